// File: rtl/mac_accumulator_ci.sv
// Multi-cycle multiply-accumulate custom-instruction slave: signed shift-add
// multiply of A x B into a 2*DATA_W-bit sticky-overflow accumulator, read back by opcode.
module mac_accumulator_ci #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic [2:0]        n,
    input  logic [DATA_W-1:0] dataa,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    localparam int ACC_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ACC_W-1:0]  mcand_q, mcand_d;
    logic [ACC_W-1:0]  prod_q, prod_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [DATA_W-1:0] mag_b;
    logic              neg;
    logic [ACC_W-1:0]  prod_signed;
    logic [ACC_W-1:0]  sum;

    // Two's-complement magnitude; the most negative value maps to 2^(DATA_W-1) unsigned.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
    endfunction

    always_comb begin
        mag_b       = mag(b_q);
        neg         = a_q[DATA_W-1] ^ b_q[DATA_W-1];
        prod_signed = neg ? (~prod_q + ACC_W'(1)) : prod_q;
        sum         = acc_q + prod_signed;

        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = n;
                    state_d = S_DONE;
                    case (n)
                        3'd0: a_d = dataa;
                        3'd1: begin
                            b_d     = dataa;
                            mcand_d = ACC_W'(mag(a_q));
                            prod_d  = '0;
                            count_d = '0;
                            state_d = S_MUL;
                        end
                        3'd4: begin
                            acc_d = '0;
                            ovf_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                // Multiplier bit selected by the counter so B itself stays intact.
                if (mag_b[count_q])
                    prod_d = prod_q + mcand_q;
                mcand_d = mcand_q << 1;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_LAST)
                    state_d = S_ACC;
            end
            S_ACC: begin
                acc_d = sum;
                if ((acc_q[ACC_W-1] == prod_signed[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]))
                    ovf_d = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                case (op_q)
                    3'd1, 3'd2: result_d = acc_q[DATA_W-1:0];
                    3'd3:       result_d = acc_q[ACC_W-1:DATA_W];
                    3'd5:       result_d = {{(DATA_W-1){1'b0}}, ovf_q};
                    default:    result_d = '0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (clk_en) begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;
endmodule
